// File: rtl/preamble_pkg.sv
// preamble_pkg: shared states, sizes and IQ packing for the preamble sequencer
package preamble_pkg;
  localparam int STF_PERIOD = 16;
  localparam int LTF_SYM_LEN = 64;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_STF = 3'd1;
  localparam logic [2:0] S_LTF_GI = 3'd2;
  localparam logic [2:0] S_LTF = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_t;
  // Sign-extend to 17 bits so the sum cannot overflow before the halving shift
  function automatic logic [15:0] half_sum(input logic [15:0] a, input logic [15:0] b);
    return 16'(({a[15], a} + {b[15], b}) >> 1);
  endfunction
endpackage

// File: rtl/preamble_seq_if.sv
// preamble_seq_if: control, ROM address/data and sample stream bundle of the preamble sequencer
interface preamble_seq_if;
  logic start;
  logic abort;
  logic [3:0] stf_addr;
  logic [31:0] stf_data;
  logic [5:0] ltf_addr;
  logic [31:0] ltf_data;
  logic [31:0] sample_out;
  logic sample_valid;
  logic sample_ready;
  logic busy;
  logic done;
  logic [8:0] sample_cnt;
  modport master (
    input start, abort, stf_data, ltf_data, sample_ready,
    output stf_addr, ltf_addr, sample_out, sample_valid, busy, done, sample_cnt
  );
  modport slave (
    output start, abort, stf_data, ltf_data, sample_ready,
    input stf_addr, ltf_addr, sample_out, sample_valid, busy, done, sample_cnt
  );
endinterface

// File: rtl/preamble_seq_win.sv
// preamble_win: per-component (a+b)>>>1 of two packed IQ words for preamble edge windowing
module preamble_win
  import preamble_pkg::*;
(
  input  iq_t a,
  input  iq_t b,
  output iq_t y
);
  assign y.i = half_sum(a.i, b.i);
  assign y.q = half_sum(a.q, b.q);
endmodule

// File: rtl/preamble_seq.sv
// preamble_seq: 802.11a/g L-STF/L-LTF preamble sequencer; PREAMBLE_WINDOW_EN adds boundary windowing
module preamble_seq
  import preamble_pkg::*;
#(
  parameter int STF_REPS = 10,
  parameter int LTF_GI_LEN = 32,
  parameter int LTF_SYMS = 2
) (
  input logic clk,
  input logic rstn,
  preamble_seq_if.master bus
);
  localparam int STF_N = STF_PERIOD * STF_REPS;
  localparam int LTF_BASE = STF_N + LTF_GI_LEN;
  localparam int N_TOT = LTF_BASE + LTF_SYM_LEN * LTF_SYMS;
  if (STF_REPS < 1 || STF_REPS > 15 || LTF_GI_LEN < 1 || LTF_GI_LEN > 64 ||
      LTF_SYMS < 1 || LTF_SYMS > 3) begin : g_param_err
    $error("preamble_seq: parameter out of range");
  end
  logic [2:0] state_q, state_d;
  logic [8:0] nidx_q, nidx_d, cnt_q, cnt_d;
  logic [31:0] sample_q, sample_d, raw, word;
  logic valid_q, valid_d, busy_q, busy_d, ld, in_stf;
  // nidx_q is the index of the next sample to load; ROM addresses derive from it
  assign in_stf = state_q == S_IDLE || state_q == S_STF;
  assign ld = !valid_q || bus.sample_ready;
  assign bus.stf_addr = in_stf ? nidx_q[3:0] : '0;
  assign bus.ltf_addr = (state_q == S_LTF_GI || state_q == S_LTF) ? 6'(nidx_q - 9'(LTF_BASE)) : '0;
  assign raw = in_stf ? bus.stf_data : bus.ltf_data;
`ifdef PREAMBLE_WINDOW_EN
  iq_t win, ltf_w;
  assign ltf_w = (nidx_q == '0) ? '0 : bus.ltf_data;
  preamble_win u_win (.a(bus.stf_data), .b(ltf_w), .y(win));
  assign word = (nidx_q == '0 || nidx_q == 9'(STF_N)) ? win : raw;
`else
  assign word = raw;
`endif
  always_comb begin
    state_d = state_q;
    nidx_d = nidx_q;
    cnt_d = cnt_q;
    sample_d = sample_q;
    valid_d = valid_q;
    busy_d = busy_q;
    if (bus.abort || (state_q == S_DRAIN && bus.sample_ready)) begin
      state_d = S_IDLE;
      nidx_d = '0;
      cnt_d = '0;
      valid_d = 1'b0;
      busy_d = 1'b0;
    end else if (ld && state_q != S_DRAIN && (state_q != S_IDLE || bus.start)) begin
      sample_d = word;
      valid_d = 1'b1;
      busy_d = 1'b1;
      cnt_d = nidx_q;
      nidx_d = nidx_q + 9'd1;
      state_d = (state_q == S_IDLE) ? S_STF :
                (state_q == S_STF) ? (nidx_q == 9'(STF_N - 1) ? S_LTF_GI : S_STF) :
                (state_q == S_LTF_GI) ? (nidx_q == 9'(LTF_BASE - 1) ? S_LTF : S_LTF_GI) :
                (nidx_q == 9'(N_TOT - 1) ? S_DRAIN : S_LTF);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      nidx_q <= '0;
      cnt_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nidx_q <= nidx_d;
      cnt_q <= cnt_d;
      sample_q <= sample_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign bus.sample_out = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.done = state_q == S_DRAIN && bus.sample_ready && !bus.abort;
endmodule
